// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: instruction length, field format codes and the
// major opcodes that the control unit also decodes.
package rv32i_pkg;

    localparam int ILEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENCODE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FULL   = 2'd3
    } enc_state_e;

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational RV32I field packer. Range checks on the immediate are only
// enforced when RV32I_ENC_IMM_CHECK_EN is defined; otherwise range_ok is 1.
module rv32i_imm_pack
    import rv32i_pkg::*;
(
    input  logic [2:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [31:0]     imm,
    output logic [ILEN-1:0] word,
    output logic            range_ok
);

    always_comb begin
        word = '0;
        case (fmt_e'(fmt))
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = '0;
        endcase
    end

`ifdef RV32I_ENC_IMM_CHECK_EN
    // Signed range checks: the bits above the field must all copy its sign bit.
    always_comb begin
        range_ok = 1'b1;
        case (fmt_e'(fmt))
            FMT_I, FMT_S: range_ok = (imm[31:11] == {21{imm[11]}});
            FMT_B:        range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
            FMT_J:        range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
            FMT_U:        range_ok = (imm[11:0] == 12'd0);
            default:      range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Field-level RV32I instruction writer: accepts a field set, packs it and writes
// it to the next instruction-memory word. Optional macro: RV32I_ENC_IMM_CHECK_EN.
module rv32i_instr_encoder
    import rv32i_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    input  logic                  clear,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err,
    output logic [1:0]            fsm_state
);

    // Handshake: a field set transfers on a rising edge where in_valid and
    // in_ready are both 1; in_ready is 1 only in IDLE, outside reset and clear.

    enc_state_e state, state_next;

    logic [2:0]            f_fmt;
    logic [6:0]            f_opcode;
    logic [4:0]            f_rd, f_rs1, f_rs2;
    logic [2:0]            f_funct3;
    logic [6:0]            f_funct7;
    logic [31:0]           f_imm;
    logic [ILEN-1:0]       packed_word;
    logic                  range_ok;
    logic                  set_ok;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   count_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    rv32i_imm_pack u_pack (
        .fmt      (f_fmt),
        .opcode   (f_opcode),
        .rd       (f_rd),
        .rs1      (f_rs1),
        .rs2      (f_rs2),
        .funct3   (f_funct3),
        .funct7   (f_funct7),
        .imm      (f_imm),
        .word     (packed_word),
        .range_ok (range_ok)
    );

    assign set_ok   = (f_fmt <= 3'd5) && range_ok;
    assign in_ready = (state == ST_IDLE) && !reset && !clear;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = ST_ENCODE;
            ST_ENCODE: state_next = set_ok ? ST_WRITE : ST_IDLE;
            ST_WRITE:  if (mem_ack) state_next = (addr_cnt == '1) ? ST_FULL : ST_IDLE;
            ST_FULL:   state_next = ST_FULL;
            default:   state_next = ST_IDLE;
        endcase
        if (clear) state_next = ST_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_fmt    <= '0;
            f_opcode <= '0;
            f_rd     <= '0;
            f_rs1    <= '0;
            f_rs2    <= '0;
            f_funct3 <= '0;
            f_funct7 <= '0;
            f_imm    <= '0;
            wdata_q  <= '0;
            addr_cnt <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else if (clear) begin
            addr_cnt <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                f_fmt    <= in_fmt;
                f_opcode <= in_opcode;
                f_rd     <= in_rd;
                f_rs1    <= in_rs1;
                f_rs2    <= in_rs2;
                f_funct3 <= in_funct3;
                f_funct7 <= in_funct7;
                f_imm    <= in_imm;
            end
            if (state == ST_ENCODE) begin
                if (set_ok) wdata_q <= packed_word;
                else        err_q   <= 1'b1;
            end
            // Address wraps to 0 naturally when the last word is written.
            if (state == ST_WRITE && mem_ack) begin
                addr_cnt <= addr_cnt + 1'b1;
                count_q  <= count_q + 1'b1;
            end
        end
    end

    assign mem_we    = (state == ST_WRITE);
    assign mem_addr  = addr_cnt;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign full      = (state == ST_FULL);
    assign err       = err_q;
    assign fsm_state = state;

endmodule
